// File: rtl/huffman_encoder.sv
// Huffman bit packer: appends code + extra bits to a 24-bit accumulator
// and emits MSB-first bytes, with a zero-padded flush of the tail.
module huffman_encoder #(
  parameter int HUFF_CODE_LEN = 8,
  parameter int HUFF_LEN_LEN  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pending,
  input  logic                     sym_vld,
  output logic                     sym_rdy,
  input  logic [HUFF_CODE_LEN-1:0] sym_code,
  input  logic [HUFF_LEN_LEN-1:0]  sym_len,
  input  logic [5:0]               ext_val,
  input  logic [2:0]               ext_len,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     data_out_vld,
  output logic [7:0]               data_out,
  input  logic                     data_out_rdy,
  output logic [15:0]              byte_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] bcnt_q, bcnt_d;

  logic [HUFF_CODE_LEN+7:0] code_ext;
  logic [7:0]  code8, code_m;
  logic [5:0]  ext_m;
  logic [3:0]  clen;
  logic [2:0]  elen;
  logic [13:0] fld;
  logic [4:0]  tot, sh;
  logic [23:0] ins;
  logic        sym_hs, out_hs;

  assign code_ext = {8'b0, sym_code};
  assign code8    = code_ext[7:0];

  assign clen = (sym_len > HUFF_LEN_LEN'(8)) ? 4'd8 : 4'(sym_len);
  assign elen = (ext_len == 3'd7) ? 3'd6 : ext_len;

  assign code_m = code8 & ~(8'hFF << clen);
  assign ext_m  = ext_val & ~(6'h3F << elen);
  assign fld    = ({6'b0, code_m} << elen) | {8'b0, ext_m};
  assign tot    = 5'(clen) + 5'(elen);

  // field MSB lands at bit 23-cnt; cnt<8 and tot<=14 keep sh >= 3
  assign sh  = 5'd24 - cnt_q - tot;
  assign ins = {10'b0, fld} << sh;

  assign sym_rdy = rst_n & (state_q == RUN)
                 & (cnt_q < 5'd8) & ~pending;

  assign data_out_vld = ~pending
    & (((state_q == RUN) & (cnt_q >= 5'd8))
     | ((state_q == FLUSH) & (cnt_q != 5'd0)));

  assign data_out   = acc_q[23:16];
  assign flush_done = (state_q == DONE) & ~pending;
  assign byte_cnt   = bcnt_q;

  assign sym_hs = sym_vld & sym_rdy;
  assign out_hs = data_out_vld & data_out_rdy;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    if (sym_hs) begin
      acc_d = acc_q | ins;
      cnt_d = cnt_q + tot;
    end
    if (out_hs) begin
      acc_d  = acc_q << 8;
      cnt_d  = (cnt_q >= 5'd8) ? cnt_q - 5'd8 : 5'd0;
      bcnt_d = bcnt_q + 16'd1;
    end
    if (!pending) begin
      unique case (1'b1)
        (state_q == RUN): begin
          if (flush_req) state_d = FLUSH;
        end
        (state_q == FLUSH): begin
          if (cnt_q == 5'd0) state_d = DONE;
        end
        (state_q == DONE): begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: bit-queue reference model checked
// every cycle, directed scenarios followed by random traffic.
module tb_huffman_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pending = 1'b0;
  logic        sym_vld = 1'b0;
  logic        sym_rdy;
  logic [7:0]  sym_code = '0;
  logic [3:0]  sym_len = '0;
  logic [5:0]  ext_val = '0;
  logic [2:0]  ext_len = '0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        data_out_vld;
  logic [7:0]  data_out;
  logic        data_out_rdy = 1'b0;
  logic [15:0] byte_cnt;

  huffman_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pending      (pending),
    .sym_vld      (sym_vld),
    .sym_rdy      (sym_rdy),
    .sym_code     (sym_code),
    .sym_len      (sym_len),
    .ext_val      (ext_val),
    .ext_len      (ext_len),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .data_out_vld (data_out_vld),
    .data_out     (data_out),
    .data_out_rdy (data_out_rdy),
    .byte_cnt     (byte_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: stream bits waiting to be emitted, oldest first
  bit          mq[$];
  int          mode;
  logic [15:0] mcnt;
  logic [7:0]  got_q[$];
  int          done_seen;

  task automatic model_reset();
    mq.delete();
    mode = 0;
    mcnt = '0;
  endtask

  function automatic logic [7:0] head_byte();
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      if (i < mq.size()) b[7-i] = mq[i];
    return b;
  endfunction

  task automatic push_sym();
    int cl, el;
    cl = (sym_len > 4'd8) ? 8 : int'(sym_len);
    el = (ext_len == 3'd7) ? 6 : int'(ext_len);
    for (int i = cl - 1; i >= 0; i--) mq.push_back(sym_code[i]);
    for (int i = el - 1; i >= 0; i--) mq.push_back(ext_val[i]);
  endtask

  task automatic pop_byte();
    repeat (8) if (mq.size() > 0) void'(mq.pop_front());
    mcnt++;
  endtask

  task automatic tick();
    logic       e_rdy, e_vld, e_done;
    logic [7:0] e_data, obs;
    int         sz;
    @(negedge clk);
    sz     = mq.size();
    e_rdy  = (mode == 0) && (sz < 8) && !pending;
    e_vld  = !pending && (((mode == 0) && (sz >= 8))
                       || ((mode == 1) && (sz > 0)));
    e_data = head_byte();
    e_done = (mode == 2) && !pending;
    check("sym_rdy", sym_rdy, e_rdy);
    check("vld", data_out_vld, e_vld);
    if (e_vld) check("data", data_out, e_data);
    check("flush_done", flush_done, e_done);
    check("byte_cnt", byte_cnt, mcnt);
    obs = data_out;
    if (flush_done) done_seen++;
    @(posedge clk);
    if (!pending) begin
      case (mode)
        0: begin
          if (e_rdy && sym_vld) push_sym();
          else if (e_vld && data_out_rdy) begin
            got_q.push_back(obs);
            pop_byte();
          end
          if (flush_req) mode = 1;
        end
        1: begin
          if (e_vld && data_out_rdy) begin
            got_q.push_back(obs);
            pop_byte();
          end
          if (sz == 0) mode = 2;
        end
        default: begin
          mode = 0;
          mq.delete();
        end
      endcase
    end
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] l,
                      input logic [5:0] ev, input logic [2:0] el);
    sym_vld  = 1'b1;
    sym_code = c;
    sym_len  = l;
    ext_val  = ev;
    ext_len  = el;
    tick();
    sym_vld  = 1'b0;
  endtask

  initial begin
    model_reset();
    done_seen = 0;
    #2;
    check("rst_rdy", sym_rdy, 1'b0);
    check("rst_vld", data_out_vld, 1'b0);
    check("rst_done", flush_done, 1'b0);
    check("rst_bcnt", byte_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two short codes packing into one byte
    data_out_rdy = 1'b1;
    got_q.delete();
    send(8'h05, 4'd3, 6'd0, 3'd0);
    send(8'h19, 4'd5, 6'd0, 3'd0);
    tick();
    check("b9_n", got_q.size(), 1);
    if (got_q.size() > 0) check("b9_v", got_q[0], 8'hB9);
    check("b9_bcnt", byte_cnt, 16'd1);

    // code plus extra bits, then flush the tail
    got_q.delete();
    done_seen = 0;
    send(8'hA5, 4'd8, 6'b110011, 3'd6);
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (4) tick();
    check("fl_n", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("fl_b0", got_q[0], 8'hA5);
      check("fl_b1", got_q[1], 8'hCC);
    end
    check("fl_done", done_seen, 1);

    // backpressure hold
    got_q.delete();
    data_out_rdy = 1'b0;
    send(8'h3C, 4'd8, 6'd0, 3'd0);
    repeat (5) tick();
    data_out_rdy = 1'b1;
    tick();
    check("bp_n", got_q.size(), 1);
    if (got_q.size() > 0) check("bp_v", got_q[0], 8'h3C);

    // empty flush
    done_seen = 0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (3) tick();
    check("ef_done", done_seen, 1);

    // pending freeze with a byte valid and a symbol offered
    got_q.delete();
    data_out_rdy = 1'b0;
    send(8'h5A, 4'd8, 6'd0, 3'd0);
    pending  = 1'b1;
    data_out_rdy = 1'b1;
    sym_vld  = 1'b1;
    sym_code = 8'hFF;
    sym_len  = 4'd4;
    repeat (3) tick();
    pending = 1'b0;
    sym_vld = 1'b0;
    tick();
    check("pd_n", got_q.size(), 1);
    if (got_q.size() > 0) check("pd_v", got_q[0], 8'h5A);

    // reset in the middle of a flush holding 13 bits
    data_out_rdy = 1'b0;
    send(8'hFF, 4'd8, 6'h1F, 3'd5);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mr_vld", data_out_vld, 1'b0);
    check("mr_rdy", sym_rdy, 1'b0);
    check("mr_done", flush_done, 1'b0);
    check("mr_bcnt", byte_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    data_out_rdy = 1'b1;
    repeat (5) tick();
    check("mr_none", got_q.size(), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sym_vld      = ($urandom_range(0, 9) < 6);
      sym_code     = 8'($urandom);
      sym_len      = 4'($urandom_range(0, 15));
      ext_val      = 6'($urandom);
      ext_len      = 3'($urandom_range(0, 7));
      flush_req    = ($urandom_range(0, 19) == 0);
      pending      = ($urandom_range(0, 9) == 0);
      data_out_rdy = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
